// File: rtl/systolic_array_3x3.sv
// Output-stationary 3x3 systolic MAC array; each PE accumulates one element of C = A*B.
// Optional build macro SYSTOLIC_ACC_SATURATE_EN clamps product and accumulator instead of wrapping.

module systolic_pe #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [DATA_W-1:0] acc
);

    logic [DATA_W-1:0] acc_next;

`ifdef SYSTOLIC_ACC_SATURATE_EN
    logic [2*DATA_W-1:0] full_prod;
    logic [DATA_W-1:0]   prod;
    logic [DATA_W:0]     sum;

    always_comb begin
        full_prod = {{DATA_W{1'b0}}, a_in} * {{DATA_W{1'b0}}, b_in};
        prod      = (|full_prod[2*DATA_W-1:DATA_W]) ? '1 : full_prod[DATA_W-1:0];
        sum       = {1'b0, acc} + {1'b0, prod};
        acc_next  = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
    end
`else
    logic [DATA_W-1:0] prod;

    // Only the low DATA_W bits of the product matter when wrapping.
    always_comb begin
        prod     = a_in * b_in;
        acc_next = acc + prod;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else begin
            a_out <= a_in;
            b_out <= b_in;
            acc   <= acc_next;
        end
    end

endmodule

module systolic_array_3x3 #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] a2,
    input  logic [DATA_W-1:0] a3,
    input  logic [DATA_W-1:0] b1,
    input  logic [DATA_W-1:0] b2,
    input  logic [DATA_W-1:0] b3,
    output logic [DATA_W-1:0] c1,
    output logic [DATA_W-1:0] c2,
    output logic [DATA_W-1:0] c3,
    output logic [DATA_W-1:0] c4,
    output logic [DATA_W-1:0] c5,
    output logic [DATA_W-1:0] c6,
    output logic [DATA_W-1:0] c7,
    output logic [DATA_W-1:0] c8,
    output logic [DATA_W-1:0] c9
);

    logic [DATA_W-1:0] a_edge [3];
    logic [DATA_W-1:0] b_edge [3];
    logic [DATA_W-1:0] a_in   [3][3];
    logic [DATA_W-1:0] b_in   [3][3];
    logic [DATA_W-1:0] a_fwd  [3][3];
    logic [DATA_W-1:0] b_fwd  [3][3];
    logic [DATA_W-1:0] acc    [3][3];

    assign a_edge[0] = a1;
    assign a_edge[1] = a2;
    assign a_edge[2] = a3;
    assign b_edge[0] = b1;
    assign b_edge[1] = b2;
    assign b_edge[2] = b3;

    // Operands shift right along rows and down along columns; edge PEs take ports.
    for (genvar r = 0; r < 3; r++) begin : g_row
        for (genvar c = 0; c < 3; c++) begin : g_col
            if (c == 0) begin : g_a_port
                assign a_in[r][c] = a_edge[r];
            end else begin : g_a_fwd
                assign a_in[r][c] = a_fwd[r][c-1];
            end

            if (r == 0) begin : g_b_port
                assign b_in[r][c] = b_edge[c];
            end else begin : g_b_fwd
                assign b_in[r][c] = b_fwd[r-1][c];
            end

            systolic_pe #(
                .DATA_W (DATA_W)
            ) u_pe (
                .clk   (clk),
                .rst   (rst),
                .a_in  (a_in[r][c]),
                .b_in  (b_in[r][c]),
                .a_out (a_fwd[r][c]),
                .b_out (b_fwd[r][c]),
                .acc   (acc[r][c])
            );
        end
    end

    assign c1 = acc[0][0];
    assign c2 = acc[0][1];
    assign c3 = acc[0][2];
    assign c4 = acc[1][0];
    assign c5 = acc[1][1];
    assign c6 = acc[1][2];
    assign c7 = acc[2][0];
    assign c8 = acc[2][1];
    assign c9 = acc[2][2];

endmodule

// File: tb/tb_systolic_array_3x3.sv
// Self-checking bench for systolic_array_3x3: table matmuls, corner sequences,
// and random streams checked against a timing-rule reference model.

module tb_systolic_array_3x3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] a1 = '0, a2 = '0, a3 = '0;
    logic [31:0] b1 = '0, b2 = '0, b3 = '0;
    logic [31:0] c1, c2, c3, c4, c5, c6, c7, c8, c9;
    logic [31:0] cv [9];

    int checks = 0;
    int errors = 0;

    systolic_array_3x3 #(.DATA_W(32)) dut (
        .clk (clk), .rst (rst),
        .a1 (a1), .a2 (a2), .a3 (a3),
        .b1 (b1), .b2 (b2), .b3 (b3),
        .c1 (c1), .c2 (c2), .c3 (c3),
        .c4 (c4), .c5 (c5), .c6 (c6),
        .c7 (c7), .c8 (c8), .c9 (c9)
    );

    always #5 clk = ~clk;

    assign cv[0] = c1; assign cv[1] = c2; assign cv[2] = c3;
    assign cv[3] = c4; assign cv[4] = c5; assign cv[5] = c6;
    assign cv[6] = c7; assign cv[7] = c8; assign cv[8] = c9;

    // Reference: port values per edge since reset, and accumulators.
    localparam int HDEPTH = 64;
    logic [31:0] ah [3][HDEPTH];
    logic [31:0] bh [3][HDEPTH];
    logic [31:0] macc [9];
    int          edge_n = 0;

    typedef struct {
        logic [31:0] a [9];
        logic [31:0] b [9];
        logic [31:0] c [9];
    } vec_t;

    vec_t tbl [3];

    function automatic logic [31:0] mac(input logic [31:0] acc,
                                        input logic [31:0] x,
                                        input logic [31:0] y);
        logic [63:0] full;
        logic [32:0] s;
        logic [31:0] p;
        full = {32'd0, x} * {32'd0, y};
`ifdef SYSTOLIC_ACC_SATURATE_EN
        p = (full > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : full[31:0];
        s = {1'b0, acc} + {1'b0, p};
        return (s > 33'h0_FFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
`else
        p = full[31:0];
        s = {1'b0, acc} + {1'b0, p};
        return s[31:0];
`endif
    endfunction

    // PE(r,c) at edge e consumes a(r+1) from edge e-c and b(c+1) from edge e-r.
    task automatic model_edge();
        logic [31:0] x, y;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                x = (edge_n - c >= 0) ? ah[r][edge_n-c] : 32'd0;
                y = (edge_n - r >= 0) ? bh[c][edge_n-r] : 32'd0;
                macc[3*r+c] = mac(macc[3*r+c], x, y);
            end
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        for (int i = 0; i < 9; i++)
            chk($sformatf("%s_c%0d", tag, i + 1), cv[i], macc[i]);
    endtask

    task automatic model_clear();
        edge_n = 0;
        for (int i = 0; i < 9; i++) macc[i] = '0;
    endtask

    // Drive one edge's operands, clock it, and advance the model.
    task automatic tick(input logic [31:0] av0, av1, av2, bv0, bv1, bv2);
        a1 = av0; a2 = av1; a3 = av2;
        b1 = bv0; b2 = bv1; b3 = bv2;
        if (edge_n >= HDEPTH) begin
            $display("FAIL history_overflow got %0d expected <%0d", edge_n, HDEPTH);
            $fatal(1);
        end
        ah[0][edge_n] = av0; ah[1][edge_n] = av1; ah[2][edge_n] = av2;
        bh[0][edge_n] = bv0; bh[1][edge_n] = bv1; bh[2][edge_n] = bv2;
        @(posedge clk);
        #1;
        model_edge();
        edge_n++;
    endtask

    task automatic zero_tick();
        tick(0, 0, 0, 0, 0, 0);
    endtask

    // Called #1 after a posedge; the next posedge becomes edge 0.
    task automatic do_reset();
        a1 = 0; a2 = 0; a3 = 0; b1 = 0; b2 = 0; b3 = 0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    // Skewed feed edge t: a(r+1)=A[r][t-r], b(c+1)=B[t-c][c].
    function automatic logic [31:0] fa(input logic [31:0] m[9], input int r, input int t);
        return (t - r >= 0 && t - r < 3) ? m[3*r + (t-r)] : 32'd0;
    endfunction

    function automatic logic [31:0] fb(input logic [31:0] m[9], input int c, input int t);
        return (t - c >= 0 && t - c < 3) ? m[3*(t-c) + c] : 32'd0;
    endfunction

    task automatic feed(input logic [31:0] ma[9], input logic [31:0] mb[9],
                        input int last_t, input string tag, input logic [31:0] c1_exp,
                        input bit check_c1);
        for (int t = 0; t <= last_t; t++) begin
            tick(fa(ma, 0, t), fa(ma, 1, t), fa(ma, 2, t),
                 fb(mb, 0, t), fb(mb, 1, t), fb(mb, 2, t));
            if (check_c1 && t == 2) chk({tag, "_c1_early"}, c1, c1_exp);
        end
    endtask

    logic [31:0] ra [9];
    logic [31:0] rb [9];
    logic [31:0] rc [9];

    initial begin
        tbl[0].a = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        tbl[0].b = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        tbl[0].c = '{30, 36, 42, 66, 81, 96, 102, 126, 150};
        tbl[1].a = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        tbl[1].b = '{2, 3, 4, 5, 6, 7, 8, 9, 10};
        tbl[1].c = '{2, 3, 4, 5, 6, 7, 8, 9, 10};
        tbl[2].a = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
        tbl[2].b = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
        tbl[2].c = '{3, 3, 3, 3, 3, 3, 3, 3, 3};

        // Power-on reset
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 9; i++) chk($sformatf("rst_init_c%0d", i + 1), cv[i], 32'd0);

        // Async reset between edges after nonzero traffic
        for (int k = 0; k < 5; k++) tick(k + 3, k + 5, 7, 11, k + 2, 9);
        chk("busy_c1_nonzero", (c1 != 0) ? 32'd1 : 32'd0, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 9; i++) chk($sformatf("rst_async_c%0d", i + 1), cv[i], 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();

        // Table matmuls, then hold
        for (int v = 0; v < 3; v++) begin
            do_reset();
            feed(tbl[v].a, tbl[v].b, 6, $sformatf("mm%0d", v), tbl[v].c[0], 1'b1);
            for (int i = 0; i < 9; i++)
                chk($sformatf("mm%0d_c%0d", v, i + 1), cv[i], tbl[v].c[i]);
            if (v == 0) begin
                for (int k = 0; k < 20; k++) zero_tick();
                for (int i = 0; i < 9; i++)
                    chk($sformatf("hold_c%0d", i + 1), cv[i], tbl[0].c[i]);
            end
        end

        // Single pulse reaches only PE(0,0)
        do_reset();
        tick(2, 0, 0, 3, 0, 0);
        for (int k = 0; k < 6; k++) zero_tick();
        for (int i = 0; i < 9; i++)
            chk($sformatf("pulse_c%0d", i + 1), cv[i], (i == 0) ? 32'd6 : 32'd0);

        // b1 reaches row 1 one edge later
        do_reset();
        tick(0, 5, 0, 1, 0, 0);
        for (int i = 0; i < 9; i++)
            chk($sformatf("prop_e0_c%0d", i + 1), cv[i], 32'd0);
        tick(0, 5, 0, 1, 0, 0);
        for (int i = 0; i < 9; i++)
            chk($sformatf("prop_e1_c%0d", i + 1), cv[i], (i == 3) ? 32'd5 : 32'd0);
        for (int k = 0; k < 4; k++) zero_tick();
        chk_model("prop_tail");

        // Product overflow
        do_reset();
        tick(32'h10000, 0, 0, 32'h10000, 0, 0);
        tick(32'h10000, 0, 0, 32'h10000, 0, 0);
`ifdef SYSTOLIC_ACC_SATURATE_EN
        chk("wrap_c1", c1, 32'hFFFF_FFFF);
`else
        chk("wrap_c1", c1, 32'd0);
`endif
        chk_model("wrap");

        // Mid-run reset then replay
        do_reset();
        feed(tbl[0].a, tbl[0].b, 3, "mid", 32'd0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_c1", c1, 32'd0);
        chk("mid_rst_c5", c5, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        feed(tbl[0].a, tbl[0].b, 6, "replay", tbl[0].c[0], 1'b1);
        for (int i = 0; i < 9; i++)
            chk($sformatf("replay_c%0d", i + 1), cv[i], tbl[0].c[i]);

        // Random small matrices: model every edge plus plain A*B at the end
        for (int trial = 0; trial < 4; trial++) begin
            do_reset();
            for (int i = 0; i < 9; i++) begin
                ra[i] = $urandom_range(0, 255);
                rb[i] = $urandom_range(0, 255);
            end
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    rc[3*r+c] = ra[3*r]*rb[c] + ra[3*r+1]*rb[3+c] + ra[3*r+2]*rb[6+c];
            for (int t = 0; t <= 6; t++) begin
                tick(fa(ra, 0, t), fa(ra, 1, t), fa(ra, 2, t),
                     fb(rb, 0, t), fb(rb, 1, t), fb(rb, 2, t));
                chk_model($sformatf("rmm%0d_t%0d", trial, t));
            end
            for (int i = 0; i < 9; i++)
                chk($sformatf("rmm%0d_ab_c%0d", trial, i + 1), cv[i], rc[i]);
        end

        // Random full-width unskewed streams
        for (int trial = 0; trial < 3; trial++) begin
            do_reset();
            for (int t = 0; t < 12; t++) begin
                tick($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
                chk_model($sformatf("rstream%0d_t%0d", trial, t));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
